// File: rtl/meteor_pkg.sv
// Shared definitions for the meteor-dodge game: playfield geometry,
// slot indexing, scheduler FSM states and the spawn LFSR step.
package meteor_pkg;

    localparam int DEF_SCREEN_W    = 640;
    localparam int DEF_SCREEN_H    = 480;
    localparam int DEF_METEOR_SIZE = 16;
    localparam int MAX_METEORS     = 8;

    localparam logic [15:0] LFSR_TAPS     = 16'hB400;
    localparam logic [15:0] DEF_LFSR_SEED = 16'hACE1;

    // Wide enough to address up to MAX_METEORS slots.
    typedef logic [2:0] slot_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MOVE  = 2'd1,
        ST_SPAWN = 2'd2
    } sched_state_t;

    // One step of the right-shifting Galois LFSR.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/meteor_scheduler_if.sv
// Control and slot-state bundle between the game controller (master)
// and the meteor scheduler (slave).
interface meteor_scheduler_if #(
    parameter int NUM_METEORS = 6
);
    logic                        tick;
    logic                        enable;
    logic                        clear;
    logic [2:0]                  speed;
    logic [NUM_METEORS-1:0][9:0] meteor_x;
    logic [NUM_METEORS-1:0][8:0] meteor_y;
    logic [NUM_METEORS-1:0]      meteor_active;
    logic                        passed;
    logic                        spawn_dropped;
    logic                        tick_overrun;
    logic                        busy;

    modport master (
        output tick, enable, clear, speed,
        input  meteor_x, meteor_y, meteor_active,
        input  passed, spawn_dropped, tick_overrun, busy
    );

    modport slave (
        input  tick, enable, clear, speed,
        output meteor_x, meteor_y, meteor_active,
        output passed, spawn_dropped, tick_overrun, busy
    );
endinterface

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR used as the spawn x-position source.
module lfsr16
    import meteor_pkg::*;
#(
    parameter logic [15:0] SEED = DEF_LFSR_SEED
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [15:0] state_o
);

    logic [15:0] state_q;
    logic [15:0] state_d;

    // Advance every cycle; the scheduler samples whatever value is current.
    always_comb begin
        state_d = lfsr_step(state_q);
    end

    // State register, back to the seed on reset only (clear leaves it running).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/meteor_scheduler.sv
// Meteor slot pool: per game tick, sweeps every slot to move/retire it,
// then tries to allocate one free slot to a new meteor.
module meteor_scheduler
    import meteor_pkg::*;
#(
    parameter int          NUM_METEORS    = 6,
    parameter int          SCREEN_W       = DEF_SCREEN_W,
    parameter int          SCREEN_H       = DEF_SCREEN_H,
    parameter int          METEOR_SIZE    = DEF_METEOR_SIZE,
    parameter int          SPAWN_INTERVAL = 30,
    parameter logic [15:0] LFSR_SEED      = DEF_LFSR_SEED
) (
    input  logic               clk,
    input  logic               reset_n,
    meteor_scheduler_if.slave  bus
);

    localparam int              CNT_W    = (SPAWN_INTERVAL > 1) ? $clog2(SPAWN_INTERVAL) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SPAWN_INTERVAL - 1);
    localparam logic [9:0]      XRANGE   = 10'(SCREEN_W - METEOR_SIZE);
    localparam logic [9:0]      Y_LIMIT  = 10'(SCREEN_H);
    localparam slot_idx_t       LAST_IDX = slot_idx_t'(NUM_METEORS - 1);

    sched_state_t                state_q, state_d;
    slot_idx_t                   idx_q, idx_d;
    slot_idx_t                   ptr_q, ptr_d;
    logic                        pending_q, pending_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [NUM_METEORS-1:0][9:0] x_q, x_d;
    logic [NUM_METEORS-1:0][8:0] y_q, y_d;
    logic [NUM_METEORS-1:0]      active_q, active_d;
    logic                        passed_q, passed_d;
    logic                        dropped_q, dropped_d;
    logic                        overrun_q, overrun_d;

    logic [15:0] lfsr_state;
    logic [5:0]  lfsr_unused;
    logic [9:0]  spawn_v;
    logic [9:0]  spawn_x;
    logic        tick_acc;
    logic [9:0]  y_sum;
    logic        free_found;
    slot_idx_t   free_idx;
    slot_idx_t   cand;

    lfsr16 #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .clk    (clk),
        .reset_n(reset_n),
        .state_o(lfsr_state)
    );

    // Only the low ten bits feed the x position.
    assign spawn_v     = lfsr_state[9:0];
    assign lfsr_unused = lfsr_state[15:10];
    // Fold the 0..1023 range into the legal left-edge range by one subtraction.
    assign spawn_x     = (spawn_v < XRANGE) ? spawn_v : (spawn_v - XRANGE);
    assign tick_acc    = bus.tick & bus.enable;
    assign y_sum       = {1'b0, y_q[idx_q]} + {7'b0, bus.speed};

    // First free slot at or after the round-robin pointer, wrapping.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        cand       = '0;
        for (int i = 0; i < NUM_METEORS; i++) begin
            cand = slot_idx_t'((int'(ptr_q) + i) % NUM_METEORS);
            if (!free_found && !active_q[cand]) begin
                free_found = 1'b1;
                free_idx   = cand;
            end
        end
    end

    // Next-state logic: tick acceptance, slot sweep, spawn, clear override.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        pending_d = pending_q;
        cnt_d     = cnt_q;
        x_d       = x_q;
        y_d       = y_q;
        active_d  = active_q;
        passed_d  = 1'b0;
        dropped_d = 1'b0;
        overrun_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pending_q) begin
                    // A tick landing on the consume cycle becomes the new pending one.
                    state_d   = ST_MOVE;
                    idx_d     = '0;
                    pending_d = tick_acc;
                end else if (tick_acc) begin
                    state_d = ST_MOVE;
                    idx_d   = '0;
                end
            end

            ST_MOVE: begin
                if (tick_acc) begin
                    if (pending_q) overrun_d = 1'b1;
                    else           pending_d = 1'b1;
                end
                if (active_q[idx_q]) begin
                    if (y_sum >= Y_LIMIT) begin
                        active_d[idx_q] = 1'b0;
                        y_d[idx_q]      = '0;
                        passed_d        = 1'b1;
                    end else begin
                        y_d[idx_q] = y_sum[8:0];
                    end
                end
                if (idx_q == LAST_IDX) state_d = ST_SPAWN;
                else                   idx_d   = idx_q + 1'b1;
            end

            ST_SPAWN: begin
                if (tick_acc) begin
                    if (pending_q) overrun_d = 1'b1;
                    else           pending_d = 1'b1;
                end
                if (cnt_q == CNT_MAX) begin
                    if (free_found) begin
                        active_d[free_idx] = 1'b1;
                        y_d[free_idx]      = '0;
                        x_d[free_idx]      = spawn_x;
                        ptr_d              = (free_idx == LAST_IDX) ? '0 : free_idx + 1'b1;
                        cnt_d              = '0;
                    end else begin
                        // Counter stays at max so the next tick retries.
                        dropped_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
                state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase

        if (bus.clear) begin
            state_d   = ST_IDLE;
            idx_d     = '0;
            ptr_d     = '0;
            pending_d = 1'b0;
            cnt_d     = '0;
            x_d       = '0;
            y_d       = '0;
            active_d  = '0;
            passed_d  = 1'b0;
            dropped_d = 1'b0;
            overrun_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            ptr_q     <= '0;
            pending_q <= 1'b0;
            cnt_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
            active_q  <= '0;
            passed_q  <= 1'b0;
            dropped_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            x_q       <= x_d;
            y_q       <= y_d;
            active_q  <= active_d;
            passed_q  <= passed_d;
            dropped_q <= dropped_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.meteor_x      = x_q;
    assign bus.meteor_y      = y_q;
    assign bus.meteor_active = active_q;
    assign bus.passed        = passed_q;
    assign bus.spawn_dropped = dropped_q;
    assign bus.tick_overrun  = overrun_q;
    assign bus.busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_meteor_scheduler.sv
// Directed bench for meteor_scheduler with a spawn on every tick.
module tb_meteor_scheduler;

    localparam int N = 6;

    logic clk;
    logic reset_n;

    meteor_scheduler_if #(.NUM_METEORS(N)) m ();

    meteor_scheduler #(
        .NUM_METEORS   (N),
        .SCREEN_W      (640),
        .SCREEN_H      (480),
        .METEOR_SIZE   (16),
        .SPAWN_INTERVAL(1),
        .LFSR_SEED     (16'hACE1)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (m.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference LFSR: 16-bit Galois, taps B400, seed ACE1, steps every clock.
    logic [15:0] lfsr_m;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) lfsr_m <= 16'hACE1;
        else          lfsr_m <= lfsr_m[0] ? ((lfsr_m >> 1) ^ 16'hB400) : (lfsr_m >> 1);
    end

    // Pulse counters, sampled shortly after each rising edge.
    int passed_cnt = 0;
    int drop_cnt   = 0;
    int over_cnt   = 0;
    always @(posedge clk) begin
        #1;
        if (m.passed)        passed_cnt++;
        if (m.spawn_dropped) drop_cnt++;
        if (m.tick_overrun)  over_cnt++;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] map_x(input logic [9:0] v);
        return (v < 10'd624) ? v : (v - 10'd624);
    endfunction

    // Full tick: accepted at the first rising edge, SPAWN at the eighth.
    task automatic tick_sweep(output logic [9:0] v);
        @(negedge clk); m.tick = 1'b1;
        @(negedge clk); m.tick = 1'b0;
        chk("busy_in_sweep", 64'(m.busy), 64'd1);
        repeat (6) @(negedge clk);
        v = lfsr_m[9:0];
        @(negedge clk);
        chk("busy_after_sweep", 64'(m.busy), 64'd0);
    endtask

    logic [9:0]                  v;
    logic [9:0]                  exp_x [N];
    logic [N-1:0][9:0]           x_vec;
    logic [N-1:0][8:0]           y_vec;
    int                          p0, d0, o0;

    initial begin
        reset_n  = 1'b0;
        m.tick   = 1'b0;
        m.enable = 1'b1;
        m.clear  = 1'b0;
        m.speed  = 3'd0;
        for (int k = 0; k < N; k++) exp_x[k] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_active", 64'(m.meteor_active), 64'd0);
        chk("rst_x", 64'(m.meteor_x), 64'd0);
        chk("rst_y", 64'(m.meteor_y), 64'd0);
        chk("rst_busy", 64'(m.busy), 64'd0);
        chk("rst_pulses", 64'({m.passed, m.spawn_dropped, m.tick_overrun}), 64'd0);
        reset_n = 1'b1;

        // Clear together with a tick: clear wins, no sweep starts
        @(negedge clk); m.clear = 1'b1; m.tick = 1'b1;
        @(negedge clk); m.clear = 1'b0; m.tick = 1'b0;
        chk("clear_tick_busy", 64'(m.busy), 64'd0);
        chk("clear_active", 64'(m.meteor_active), 64'd0);

        // First spawn into slot 0
        m.speed = 3'd0;
        tick_sweep(v);
        exp_x[0] = map_x(v);
        chk("spawn0_active", 64'(m.meteor_active), 64'h01);
        chk("spawn0_x", 64'(m.meteor_x[0]), 64'(exp_x[0]));
        chk("spawn0_x_range", 64'(m.meteor_x[0] < 10'd624), 64'd1);
        chk("spawn0_y", 64'(m.meteor_y[0]), 64'd0);

        // 94 ticks at speed 5: slots 1..5 fill, then 89 dropped spawns
        m.speed = 3'd5;
        d0 = drop_cnt; p0 = passed_cnt;
        for (int i = 1; i <= 94; i++) begin
            tick_sweep(v);
            if (i <= 5) exp_x[i] = map_x(v);
        end
        chk("fill_active", 64'(m.meteor_active), 64'h3F);
        chk("fill_y0", 64'(m.meteor_y[0]), 64'd470);
        chk("fill_y3", 64'(m.meteor_y[3]), 64'd455);
        chk("fill_y5", 64'(m.meteor_y[5]), 64'd445);
        chk("fill_drops", 64'(drop_cnt - d0), 64'd89);
        chk("fill_passed", 64'(passed_cnt - p0), 64'd0);
        chk("fill_x3", 64'(m.meteor_x[3]), 64'(exp_x[3]));

        // Speed 7: slot 0 reaches 477 and stays; pool full so spawn drops
        m.speed = 3'd7;
        d0 = drop_cnt; p0 = passed_cnt;
        tick_sweep(v);
        chk("y477", 64'(m.meteor_y[0]), 64'd477);
        chk("y452", 64'(m.meteor_y[5]), 64'd452);
        chk("full_drop", 64'(drop_cnt - d0), 64'd1);
        chk("full_nopass", 64'(passed_cnt - p0), 64'd0);

        // Slot 0 at 484 retires, then is re-allocated in the same tick
        d0 = drop_cnt; p0 = passed_cnt;
        tick_sweep(v);
        exp_x[0] = map_x(v);
        chk("retire0_passed", 64'(passed_cnt - p0), 64'd1);
        chk("retire0_nodrop", 64'(drop_cnt - d0), 64'd0);
        chk("retire0_y0", 64'(m.meteor_y[0]), 64'd0);
        chk("retire0_x0", 64'(m.meteor_x[0]), 64'(exp_x[0]));
        chk("edge_y479", 64'(m.meteor_y[1]), 64'd479);

        // Speed 1 retires slot 1, speed 5 retires slot 2
        m.speed = 3'd1;
        tick_sweep(v);
        exp_x[1] = map_x(v);
        m.speed = 3'd5;
        tick_sweep(v);
        exp_x[2] = map_x(v);

        // Slot 3 retires and the pointer hands slot 3 straight back
        p0 = passed_cnt;
        tick_sweep(v);
        exp_x[3] = map_x(v);
        chk("retire3_passed", 64'(passed_cnt - p0), 64'd1);
        chk("retire3_active", 64'(m.meteor_active), 64'h3F);
        chk("retire3_y3", 64'(m.meteor_y[3]), 64'd0);
        for (int k = 0; k < N; k++) x_vec[k] = exp_x[k];
        chk("retire3_xvec", 64'(m.meteor_x), 64'(x_vec));
        y_vec[0] = 9'd11; y_vec[1] = 9'd10; y_vec[2] = 9'd5;
        y_vec[3] = 9'd0;  y_vec[4] = 9'd475; y_vec[5] = 9'd470;
        chk("retire3_yvec", 64'(m.meteor_y), 64'(y_vec));

        // Three ticks on consecutive cycles: run, pend, overrun
        m.speed = 3'd0;
        o0 = over_cnt; d0 = drop_cnt;
        @(negedge clk); m.tick = 1'b1;
        @(negedge clk);
        chk("ovr_busy_p1", 64'(m.busy), 64'd1);
        @(negedge clk);
        @(negedge clk); m.tick = 1'b0;
        chk("ovr_pulse", 64'(over_cnt - o0), 64'd1);
        repeat (5) @(negedge clk);
        chk("ovr_idle_gap", 64'(m.busy), 64'd0);
        @(negedge clk);
        chk("ovr_pending_run", 64'(m.busy), 64'd1);
        repeat (7) @(negedge clk);
        chk("ovr_done", 64'(m.busy), 64'd0);
        @(negedge clk);
        chk("ovr_no_third", 64'(m.busy), 64'd0);
        chk("ovr_drops", 64'(drop_cnt - d0), 64'd2);
        chk("ovr_pulse_once", 64'(over_cnt - o0), 64'd1);
        chk("ovr_yvec", 64'(m.meteor_y), 64'(y_vec));

        // Clear while MOVE is on slot 2
        m.speed = 3'd7;
        p0 = passed_cnt;
        @(negedge clk); m.tick = 1'b1;
        @(negedge clk); m.tick = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_y0", 64'(m.meteor_y[0]), 64'd18);
        chk("mid_y1", 64'(m.meteor_y[1]), 64'd17);
        m.clear = 1'b1;
        @(negedge clk); m.clear = 1'b0;
        chk("clr_active", 64'(m.meteor_active), 64'd0);
        chk("clr_x", 64'(m.meteor_x), 64'd0);
        chk("clr_y", 64'(m.meteor_y), 64'd0);
        chk("clr_busy", 64'(m.busy), 64'd0);
        chk("clr_nopass", 64'(passed_cnt - p0), 64'd0);
        @(negedge clk);
        chk("clr_stays_idle", 64'(m.busy), 64'd0);

        // Ticks are ignored while disabled
        m.enable = 1'b0;
        @(negedge clk); m.tick = 1'b1;
        @(negedge clk); m.tick = 1'b0;
        chk("dis_busy", 64'(m.busy), 64'd0);
        @(negedge clk);
        chk("dis_not_pended", 64'(m.busy), 64'd0);
        m.enable = 1'b1;

        // After clear the pointer is back at slot 0
        m.speed = 3'd0;
        tick_sweep(v);
        chk("post_clr_slot0", 64'(m.meteor_active), 64'h01);
        chk("post_clr_x0", 64'(m.meteor_x[0]), 64'(map_x(v)));

        // Asynchronous reset in the middle of a sweep
        @(negedge clk); m.tick = 1'b1;
        @(negedge clk); m.tick = 1'b0;
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_active", 64'(m.meteor_active), 64'd0);
        chk("arst_x", 64'(m.meteor_x), 64'd0);
        chk("arst_busy", 64'(m.busy), 64'd0);
        @(negedge clk); reset_n = 1'b1;

        // LFSR restarts from the seed: first spawn x tracks the reference
        tick_sweep(v);
        chk("arst_spawn_active", 64'(m.meteor_active), 64'h01);
        chk("arst_spawn_x", 64'(m.meteor_x[0]), 64'(map_x(v)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
